systolic_b_feeder: RTL and testbench

SYSTOLIC_B_FEEDER -- requirements
Module: systolic_b_feeder

---
 rtl/systolic_b_feeder_pkg.sv | 14 +
 rtl/skew_shift_reg.sv | 30 +++
 rtl/systolic_b_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_b_feeder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_b_feeder_pkg.sv
// Shared TPU definitions: operand geometry and the B-feeder FSM encoding.
package systolic_b_feeder_pkg;

    localparam int unsigned DWIDTH  = 8;
    localparam int unsigned ARRAY_N = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/skew_shift_reg.sv
// Fixed-depth delay line with synchronous clear; used to skew one feeder lane.
module skew_shift_reg #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Depth];

    // Shift one stage per clock; reset empties the whole line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/systolic_b_feeder.sv
// Reads k_len rows of B from the operand buffer and feeds them to the top edge
// of the PE array, lane j delayed by j cycles so the wavefront lines up.
module systolic_b_feeder #(
    parameter int unsigned DWIDTH  = systolic_b_feeder_pkg::DWIDTH,
    parameter int unsigned ARRAY_N = systolic_b_feeder_pkg::ARRAY_N,
    parameter int unsigned AWIDTH  = 6,
    parameter int unsigned KWIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AWIDTH-1:0]         base_addr,
    input  logic [KWIDTH-1:0]         k_len,
    output logic                      rd_en,
    output logic [AWIDTH-1:0]         rd_addr,
    input  logic [ARRAY_N*DWIDTH-1:0] rd_data,
    output logic [ARRAY_N*DWIDTH-1:0] out_b,
    output logic [ARRAY_N-1:0]        out_valid,
    output logic                      busy,
    output logic                      done
);

    import systolic_b_feeder_pkg::*;

    // Drain lasts ARRAY_N+1 cycles: counter runs 0..ARRAY_N.
    localparam int unsigned DrainW = $clog2(ARRAY_N + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(ARRAY_N);

    feed_state_e         state_q;
    logic                rd_en_q;
    logic [AWIDTH-1:0]   rd_addr_q;
    logic [KWIDTH-1:0]   remain_q;
    logic [DrainW-1:0]   drain_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                rvalid_q;

    // Job sequencer: all control outputs are registered here.
    // rd_addr is deliberately left out of reset so it holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_en_q     <= 1'b0;
            remain_q    <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (k_len == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= StRead;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_addr;
                            remain_q  <= k_len - KWIDTH'(1);
                            busy_q    <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (remain_q == '0) begin
                        state_q     <= StDrain;
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        // Natural overflow gives the modulo-2^AWIDTH wrap.
                        rd_addr_q <= rd_addr_q + AWIDTH'(1);
                        remain_q  <= remain_q - KWIDTH'(1);
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainLast) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DrainW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Marks the cycle in which rd_data answers one of our reads; reset drops
    // any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en_q;
        end
    end

    // Each lane carries {valid, data}; the first stage is the rd_data capture,
    // so lane j sees depth j+1. Data is zeroed when not valid.
    for (genvar j = 0; j < ARRAY_N; j++) begin : g_lane
        logic [DWIDTH:0] lane_in;
        logic [DWIDTH:0] lane_out;

        assign lane_in = rvalid_q ? {1'b1, rd_data[j*DWIDTH +: DWIDTH]} : '0;

        skew_shift_reg #(
            .Depth (j + 1),
            .Width (DWIDTH + 1)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .d_i   (lane_in),
            .q_o   (lane_out)
        );

        assign out_valid[j]                 = lane_out[DWIDTH];
        assign out_b[j*DWIDTH +: DWIDTH]    = lane_out[DWIDTH-1:0];
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_systolic_b_feeder.sv
// Scoreboard bench for systolic_b_feeder: stimulus posts per-cycle expectations,
// a negedge monitor compares every output against them.
module tb_systolic_b_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int KW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [KW-1:0]   k_len;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [N*DW-1:0] rd_data;
    logic [N*DW-1:0] out_b;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    systolic_b_feeder #(
        .DWIDTH  (DW),
        .ARRAY_N (N),
        .AWIDTH  (AW),
        .KWIDTH  (KW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .k_len     (k_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_b     (out_b),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    // Operand buffer: one-cycle read latency, junk on the bus otherwise.
    logic [N*DW-1:0] mem [1<<AW];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;
    int ready_cyc = 0;

    // Expectations keyed by cycle number; absent key means "expect zero".
    logic [N-1:0]    exp_valid [int];
    logic [N*DW-1:0] exp_b     [int];
    logic [AW-1:0]   exp_rd    [int];
    bit              exp_busy  [int];
    int              exp_done  [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [N-1:0]    ev;
        logic [N*DW-1:0] eb;
        bit              erd;
        bit              edn;
        if (mon_en) begin
            ev  = exp_valid.exists(cyc) ? exp_valid[cyc] : '0;
            eb  = exp_b.exists(cyc) ? exp_b[cyc] : '0;
            erd = exp_rd.exists(cyc);
            edn = exp_done.exists(cyc);
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_b", 64'(out_b), 64'(eb));
            chk("rd_en", 64'(rd_en), 64'(erd));
            if (erd) chk("rd_addr", 64'(rd_addr), 64'(exp_rd[cyc]));
            chk("busy", 64'(busy), 64'(exp_busy.exists(cyc)));
            chk("done", 64'(done), 64'(edn));
            if (edn && exp_done[cyc] >= 0) chk("rd_addr_hold", 64'(rd_addr), 64'(exp_done[cyc]));
            if (exp_valid.exists(cyc)) exp_valid.delete(cyc);
            if (exp_b.exists(cyc))     exp_b.delete(cyc);
            if (exp_rd.exists(cyc))    exp_rd.delete(cyc);
            if (exp_busy.exists(cyc))  exp_busy.delete(cyc);
            if (exp_done.exists(cyc))  exp_done.delete(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Start a job in the first cycle the feeder is idle and post what it must do.
    task automatic launch(input int b, input int k, input bit hold, input bit pulse);
        int c0;
        int a;
        int c;
        logic [N*DW-1:0] row;
        logic [N-1:0]    tv;
        logic [N*DW-1:0] tbv;
        while (cyc < ready_cyc) tick();
        base_addr = AW'(b);
        k_len     = KW'(k);
        start     = 1'b1;
        c0        = cyc;
        if (k == 0) begin
            exp_done[c0 + 1] = -1;
            ready_cyc = c0 + 2;
        end else begin
            for (int i = 0; i < k; i++) begin
                a = (b + i) % (1 << AW);
                exp_rd[c0 + 1 + i] = AW'(a);
                row = mem[a];
                for (int j = 0; j < N; j++) begin
                    c   = c0 + i + 3 + j;
                    tv  = exp_valid.exists(c) ? exp_valid[c] : '0;
                    tbv = exp_b.exists(c) ? exp_b[c] : '0;
                    tv[j] = 1'b1;
                    tbv[j*DW +: DW] = row[j*DW +: DW];
                    exp_valid[c] = tv;
                    exp_b[c]     = tbv;
                end
            end
            for (int cc = c0 + 1; cc <= c0 + k + N + 1; cc++) exp_busy[cc] = 1'b1;
            exp_done[c0 + k + N + 2] = (b + k - 1) % (1 << AW);
            ready_cyc = c0 + k + N + 3;
        end
        tick();
        if (!hold) start = 1'b0;
        if (pulse && k > 0) begin
            tick();
            start     = 1'b1;
            k_len     = KW'($urandom);
            base_addr = AW'($urandom);
            tick();
            start = 1'b0;
        end
    endtask

    // Reset in the current cycle: nothing expected beyond it survives.
    task automatic pulse_reset();
        int r;
        r     = cyc;
        reset = 1'b1;
        start = 1'b0;
        for (int c = r + 1; c <= r + 64; c++) begin
            if (exp_valid.exists(c)) exp_valid.delete(c);
            if (exp_b.exists(c))     exp_b.delete(c);
            if (exp_rd.exists(c))    exp_rd.delete(c);
            if (exp_busy.exists(c))  exp_busy.delete(c);
            if (exp_done.exists(c))  exp_done.delete(c);
        end
        tick();
        reset = 1'b0;
        ready_cyc = r + 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit hold;
        bit pul;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        k_len     = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        ready_cyc = cyc + 1;

        // Known rows: lane0 01/11/21, lane3 04/14/24.
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h1413_1211;
        mem[2] = 32'h2423_2221;
        launch(0, 3, 1'b0, 1'b0);
        launch(5, 0, 1'b0, 1'b0);
        launch(62, 4, 1'b0, 1'b0);
        // Reset in cycle 4 of an 8-row job, then a clean job.
        launch(7, 8, 1'b0, 1'b0);
        repeat (3) tick();
        pulse_reset();
        launch(40, 5, 1'b0, 1'b0);
        // start held across two jobs.
        launch(10, 3, 1'b1, 1'b0);
        launch(20, 2, 1'b0, 1'b0);
        // Stray start during READ.
        launch(30, 5, 1'b0, 1'b1);

        repeat (40) begin
            while (cyc < ready_cyc) tick();
            repeat (4) mem[$urandom_range(0, (1 << AW) - 1)] = $urandom;
            if ($urandom_range(0, 9) == 0)      k = 0;
            else if ($urandom_range(0, 9) == 0) k = 31;
            else                                k = $urandom_range(1, 12);
            hold = ($urandom_range(0, 3) == 0);
            pul  = !hold && ($urandom_range(0, 2) == 0);
            launch($urandom_range(0, (1 << AW) - 1), k, hold, pul);
            if (!hold && !pul && k > 0 && $urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, k + N)) tick();
                pulse_reset();
            end
        end

        start = 1'b0;
        while (cyc < ready_cyc + 2) tick();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
